// File: rtl/mpu_alu_arbiter.sv
// mpu_alu_arbiter: round-robin front end that shares one combinational
// mpu_alu between NREQ requesters. It handles one operation at a time:
// accept (IDLE) -> ALU settles (EXEC) -> hold result until acked (RESP).
module mpu_alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_size,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [64*NREQ-1:0]   req_o0,
  input  logic [64*NREQ-1:0]   req_o1,
  input  logic [64*NREQ-1:0]   req_o2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_res,
  output logic [7:0]           rsp_flags,
  output logic [1:0]           alu_size,
  output logic [3:0]           alu_op,
  output logic [63:0]          alu_o0,
  output logic [63:0]          alu_o1,
  output logic [63:0]          alu_o2,
  input  logic [63:0]          alu_res,
  input  logic [7:0]           alu_flags,
  output logic                 busy,
  output logic [31:0]          ops_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] grant;
  logic             found;
  logic             accept;
  logic             done;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign accept = (state == IDLE) && found;
  assign done   = (state == RESP) && rsp_ready[owner];

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic: EXEC always lasts one cycle, RESP waits for the owner's ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ready only while idle, response valid one-hot on the owner.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (accept)         req_ready[grant] = 1'b1;
    if (state == RESP)  rsp_valid[owner] = 1'b1;
  end

  // Control registers: rotation pointer, owner and completion counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ptr      <= '0;
      owner    <= '0;
      ops_done <= '0;
    end else begin
      if (accept) owner <= grant;
      if (done) begin
        ptr      <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
        ops_done <= ops_done + 32'd1;
      end
    end
  end

  // Operand and result registers: load on accept, capture at the end of EXEC.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      alu_size  <= '0;
      alu_op    <= '0;
      alu_o0    <= '0;
      alu_o1    <= '0;
      alu_o2    <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      if (accept) begin
        alu_size <= req_size[int'(grant)*2 +: 2];
        alu_op   <= req_op[int'(grant)*4 +: 4];
        alu_o0   <= req_o0[int'(grant)*64 +: 64];
        alu_o1   <= req_o1[int'(grant)*64 +: 64];
        alu_o2   <= req_o2[int'(grant)*64 +: 64];
      end
      if (state == EXEC) begin
        rsp_res   <= alu_res;
        rsp_flags <= alu_flags;
      end
    end
  end

endmodule

// File: doc/mpu_alu_arbiter.md
Name: mpu_alu_arbiter

Overview:
Shares one combinational mpu_alu between NREQ requesters, for example the MPU execute stage and the host/debug port. It arbitrates round-robin and registers the winner's size/op/o0/o1/o2 onto the ALU inputs. It then captures res/flags into a result register and holds them until the owning requester acknowledges. Only one operation is in flight at a time.

Parameters:
NREQ, 2, number of requesters (2..4); packed request buses are NREQ slices wide, slice i belongs to requester i.

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  synchronous reset, active low
req_valid  in  NREQ  request valid per requester; must not depend on req_ready
req_ready  out  NREQ  request accepted this cycle (combinational)
req_size  in  2*NREQ  operand size per requester
req_op  in  4*NREQ  ALU opcode per requester
req_o0  in  64*NREQ  operand 0 per requester
req_o1  in  64*NREQ  operand 1 per requester
req_o2  in  64*NREQ  operand 2 per requester
rsp_valid  out  NREQ  result valid, one-hot on owner
rsp_ready  in  NREQ  result acknowledge per requester
rsp_res  out  64  captured ALU result
rsp_flags  out  8  captured ALU flags
alu_size  out  2  registered, to mpu_alu.size
alu_op  out  4  registered, to mpu_alu.op
alu_o0  out  64  registered, to mpu_alu.o0
alu_o1  out  64  registered, to mpu_alu.o1
alu_o2  out  64  registered, to mpu_alu.o2
alu_res  in  64  from mpu_alu.res
alu_flags  in  8  from mpu_alu.flags
busy  out  1  state != IDLE
ops_done  out  32  count of completed response handshakes

Behaviour:
- Reset (sys_rst_n=0 at a rising edge):
  - state=IDLE, rr pointer=0, owner=0.
  - All alu_*, rsp_res, rsp_flags and ops_done are 0; rsp_valid=0.
  - Reset overrides everything, including mid-EXEC/RESP. The in-flight op is dropped with no response, and the next cycle shows rsp_valid=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, scanning i = ptr, ptr+1, ... mod NREQ.
  - req_ready[grant]=1 only in IDLE; all other req_ready bits are 0.
  - On an edge with req_valid[grant]=1: load the grant's slice into alu_*, owner<=grant, go to EXEC.
  - With no valid requests: stay in IDLE, alu_* hold their last values.
- EXEC: lasts exactly one cycle.
  - The ALU settles combinationally from the registered alu_*.
  - At the edge: rsp_res<=alu_res, rsp_flags<=alu_flags, go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_res, rsp_flags and alu_* are stable.
  - On an edge with rsp_ready[owner]=1: ptr<=(owner+1) mod NREQ, ops_done<=ops_done+1 (wraps at 2^32), go to IDLE.
  - rsp_ready from non-owners is ignored.
- Timing:
  - Request handshake at edge k, then rsp_valid from after edge k+1.
  - With rsp_ready held high, the next request handshake is at the earliest edge k+3. Peak throughput is 1 op per 3 cycles.
  - No accept occurs in the same cycle as a response handshake.
- Opcode and size are passed through without checking. Ops outside 1..3 produce whatever the ALU outputs.
- Fairness: a continuously valid requester is served within NREQ grants.
- After a response, rsp_res and rsp_flags hold until the next EXEC capture.

Test Plan:
- Single request, requester 0, size=0, op=1, o0=0x55, o1=0xAA, o2=0x55 -> req_ready[0]=1 in the accept cycle. rsp_valid=2'b01 is seen one edge after the accept. alu_o0=0x55. rsp_res/rsp_flags equal the live mpu_alu outputs for those operands. ops_done goes 0->1 after the ack.
- Contention from reset (ptr=0): both valid, req0 op=2 (o0=0x55, o1=0x55, o2=0xFF), req1 op=3 (o0=0x54, o1=0x55), rsp_ready=11 -> req0 is granted first, req1 is accepted exactly 3 edges later. Response order is 01 then 10; ops_done=2.
- Fairness: both requesters valid for 6 ops -> grant order 0,1,0,1,0,1 and ops_done=6.
- Backpressure: rsp_ready[0]=0 for 5 cycles, while requester 1 is valid and pulses rsp_ready[1] -> rsp_valid=01 stays high and rsp_res is stable for all 5 cycles. req_ready=00 throughout; completion happens only on rsp_ready[0].
- Reset mid-operation: assert sys_rst_n=0 for one edge during EXEC -> next cycle shows state IDLE, rsp_valid=0, all alu_*=0, ops_done=0. The dropped request, if re-presented, is accepted with ptr=0 priority.
- Out-of-range op=0xF, size=3 -> passed unchanged to alu_op/alu_size, and the normal 3-state handshake completes.
